// File: rtl/mul_rs_station_if.sv
// Issue, CDB and multiplier-dispatch signal bundle for the MUL reservation station.
// master = issue stage / CDB / multiplier side, slave = the station itself.
interface mul_rs_station_if #(
  parameter int ENTRIES = 2,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 8
) ();
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic              iss_valid;
  logic [TAG_W-1:0]  iss_tag;
  logic              iss_qj_pend;
  logic [TAG_W-1:0]  iss_qj;
  logic [DATA_W-1:0] iss_vj;
  logic              iss_qk_pend;
  logic [TAG_W-1:0]  iss_qk;
  logic [DATA_W-1:0] iss_vk;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              mul_busy;
  logic              mul_start;
  logic [TAG_W-1:0]  mul_tag;
  logic [DATA_W-1:0] mul_op_a;
  logic [DATA_W-1:0] mul_op_b;

  logic              rs_full;
  logic [CNT_W-1:0]  rs_count;

  modport master (
    output iss_valid, iss_tag, iss_qj_pend, iss_qj, iss_vj,
           iss_qk_pend, iss_qk, iss_vk,
           cdb_valid, cdb_tag, cdb_data, mul_busy,
    input  mul_start, mul_tag, mul_op_a, mul_op_b, rs_full, rs_count
  );

  modport slave (
    input  iss_valid, iss_tag, iss_qj_pend, iss_qj, iss_vj,
           iss_qk_pend, iss_qk, iss_vk,
           cdb_valid, cdb_tag, cdb_data, mul_busy,
    output mul_start, mul_tag, mul_op_a, mul_op_b, rs_full, rs_count
  );
endinterface

// File: rtl/mul_rs_station.sv
// Tomasulo reservation station in front of the multiplier: issue, CDB wakeup, oldest-ready dispatch.
// Define MUL_RS_FWD_EN to let a same-cycle CDB wakeup feed dispatch directly.
module mul_rs_station #(
  parameter int ENTRIES = 2,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  mul_rs_station_if.slave  bus
);
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              qj_pend;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic              qk_pend;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } entry_t;

  // Occupancy and dispatch outputs carry reset; the entry payload does not.
  logic [ENTRIES-1:0] busy;
  logic [CNT_W-1:0]   count;
  entry_t             ent [ENTRIES];
  // age = number of older entries still resident; 0 is the oldest.
  logic [CNT_W-1:0]   age [ENTRIES];

  logic               start_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  op_a_q;
  logic [DATA_W-1:0]  op_b_q;

  logic [ENTRIES-1:0] wake_j;
  logic [ENTRIES-1:0] wake_k;
  logic [ENTRIES-1:0] ready;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   sel_age;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;

  logic               full;
  logic               issue;
  logic               dispatch;
  logic [DATA_W-1:0]  disp_a;
  logic [DATA_W-1:0]  disp_b;
  logic               cap_j;
  logic               cap_k;
  entry_t             new_ent;
  logic [CNT_W-1:0]   new_age;

  // Snoop and readiness per entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wake_j = '0;
    wake_k = '0;
    ready  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wake_j[i] = busy[i] && bus.cdb_valid && ent[i].qj_pend && (ent[i].qj == bus.cdb_tag);
      wake_k[i] = busy[i] && bus.cdb_valid && ent[i].qk_pend && (ent[i].qk == bus.cdb_tag);
`ifdef MUL_RS_FWD_EN
      ready[i]  = busy[i] && (!ent[i].qj_pend || wake_j[i]) && (!ent[i].qk_pend || wake_k[i]);
`else
      ready[i]  = busy[i] && !ent[i].qj_pend && !ent[i].qk_pend;
`endif
    end
  end

  // Oldest ready entry; ages are unique among busy entries, so the first strict minimum wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready[i] && (!sel_found || (age[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  // Lowest-index free entry, scanned from the top so the lowest index is written last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // A slot freed by this edge's dispatch is only offered to issue on the next edge.
  assign full     = !free_found;
  assign issue    = bus.iss_valid && !full;
  assign dispatch = sel_found && !bus.mul_busy;

  always_comb begin
    disp_a = ent[sel_idx].vj;
    disp_b = ent[sel_idx].vk;
`ifdef MUL_RS_FWD_EN
    if (wake_j[sel_idx]) disp_a = bus.cdb_data;
    if (wake_k[sel_idx]) disp_b = bus.cdb_data;
`endif
  end

  // Issue-time capture closes the window where the producer broadcasts while its consumer issues.
  always_comb begin
    cap_j           = bus.cdb_valid && bus.iss_qj_pend && (bus.iss_qj == bus.cdb_tag);
    cap_k           = bus.cdb_valid && bus.iss_qk_pend && (bus.iss_qk == bus.cdb_tag);
    new_ent.tag     = bus.iss_tag;
    new_ent.qj      = bus.iss_qj;
    new_ent.qk      = bus.iss_qk;
    new_ent.qj_pend = bus.iss_qj_pend && !cap_j;
    new_ent.qk_pend = bus.iss_qk_pend && !cap_k;
    new_ent.vj      = cap_j ? bus.cdb_data : bus.iss_vj;
    new_ent.vk      = cap_k ? bus.cdb_data : bus.iss_vk;
    // Youngest position counts survivors after this edge's dispatch leaves.
    new_age         = count - CNT_W'(dispatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      busy    <= '0;
      count   <= '0;
      start_q <= 1'b0;
      tag_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      start_q <= dispatch;
      if (dispatch) begin
        tag_q  <= ent[sel_idx].tag;
        op_a_q <= disp_a;
        op_b_q <= disp_b;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (dispatch && (sel_idx == IDX_W'(i))) busy[i] <= 1'b0;
        if (issue && (free_idx == IDX_W'(i)))   busy[i] <= 1'b1;
      end
      count <= count + CNT_W'(issue) - CNT_W'(dispatch);
    end
  end

  // NOTE: payload storage is not reset; busy gates every use, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (issue && (free_idx == IDX_W'(i))) begin
        ent[i] <= new_ent;
        age[i] <= new_age;
      end else begin
        if (wake_j[i]) begin
          ent[i].qj_pend <= 1'b0;
          ent[i].vj      <= bus.cdb_data;
        end
        if (wake_k[i]) begin
          ent[i].qk_pend <= 1'b0;
          ent[i].vk      <= bus.cdb_data;
        end
        if (dispatch && (age[i] > sel_age)) age[i] <= age[i] - CNT_W'(1);
      end
    end
  end

  assign bus.mul_start = start_q;
  assign bus.mul_tag   = tag_q;
  assign bus.mul_op_a  = op_a_q;
  assign bus.mul_op_b  = op_b_q;
  assign bus.rs_full   = full;
  assign bus.rs_count  = count;

  count_matches_busy: assert property (@(posedge clk) disable iff (rst)
    count == CNT_W'($countones(busy)));

endmodule

// File: tb/tb_mul_rs_station.sv
// Self-checking bench for mul_rs_station: directed vector table, reset sequences and
// randomized traffic against a queue-based reference model (queue order = issue age).
module tb_mul_rs_station;
  localparam int ENTRIES = 2;
  localparam int TAG_W   = 3;
  localparam int DATA_W  = 8;
`ifdef MUL_RS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_rs_station_if #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  mul_rs_station #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit iv; int itag; bit jp; int qj; int vj; bit kp; int qk; int vk;
    bit cv; int ctag; int cdata; bit busy;
  } stim_t;

  typedef struct {
    stim_t s;
    bit start; int tag; int a; int b; int cnt; bit full;
  } vec_t;

  typedef struct {
    int tag; bit jp; int qj; int vj; bit kp; int qk; int vk;
  } m_entry_t;

  int n_checks = 0;
  int n_fail   = 0;

  m_entry_t m_q[$];
  bit m_start;
  int m_tag, m_a, m_b;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic stim_t mk_s(bit iv, int itag, bit jp, int qj, int vj, bit kp, int qk, int vk,
                                 bit cv, int ctag, int cdata, bit busy);
    stim_t s;
    s.iv = iv; s.itag = itag; s.jp = jp; s.qj = qj; s.vj = vj;
    s.kp = kp; s.qk = qk; s.vk = vk;
    s.cv = cv; s.ctag = ctag; s.cdata = cdata; s.busy = busy;
    return s;
  endfunction

  function automatic vec_t mk_v(stim_t s, bit st, int tag, int a, int b, int cnt, bit full);
    vec_t v;
    v.s = s; v.start = st; v.tag = tag; v.a = a; v.b = b; v.cnt = cnt; v.full = full;
    return v;
  endfunction

  function automatic stim_t idle_s(bit busy);
    return mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
  endfunction

  task automatic drive(stim_t s);
    bus.iss_valid   = s.iv;
    bus.iss_tag     = TAG_W'(s.itag);
    bus.iss_qj_pend = s.jp;
    bus.iss_qj      = TAG_W'(s.qj);
    bus.iss_vj      = DATA_W'(s.vj);
    bus.iss_qk_pend = s.kp;
    bus.iss_qk      = TAG_W'(s.qk);
    bus.iss_vk      = DATA_W'(s.vk);
    bus.cdb_valid   = s.cv;
    bus.cdb_tag     = TAG_W'(s.ctag);
    bus.cdb_data    = DATA_W'(s.cdata);
    bus.mul_busy    = s.busy;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_start = 0; m_tag = 0; m_a = 0; m_b = 0;
  endtask

  // One clock edge of the specified behaviour: oldest-ready dispatch, wakeup, then issue.
  task automatic model_edge(stim_t s);
    int sel = -1;
    bit was_full = (m_q.size() == ENTRIES);
    m_entry_t e;
    for (int i = 0; i < m_q.size(); i++) begin
      bit jr = !m_q[i].jp || (FWD && s.cv && m_q[i].qj == s.ctag);
      bit kr = !m_q[i].kp || (FWD && s.cv && m_q[i].qk == s.ctag);
      if (jr && kr) begin
        sel = i;
        break;
      end
    end
    m_start = 0;
    if (sel >= 0 && !s.busy) begin
      m_start = 1;
      m_tag   = m_q[sel].tag;
      m_a     = m_q[sel].jp ? s.cdata : m_q[sel].vj;
      m_b     = m_q[sel].kp ? s.cdata : m_q[sel].vk;
      m_q.delete(sel);
    end
    if (s.cv) begin
      for (int i = 0; i < m_q.size(); i++) begin
        e = m_q[i];
        if (e.jp && e.qj == s.ctag) begin e.jp = 0; e.vj = s.cdata; end
        if (e.kp && e.qk == s.ctag) begin e.kp = 0; e.vk = s.cdata; end
        m_q[i] = e;
      end
    end
    if (s.iv) begin
      if (was_full) begin
        $display("note: issue of tag %0d while station full was dropped", s.itag);
      end else begin
        e.tag = s.itag; e.qj = s.qj; e.qk = s.qk;
        e.jp  = s.jp && !(s.cv && s.ctag == s.qj);
        e.kp  = s.kp && !(s.cv && s.ctag == s.qk);
        e.vj  = (s.jp && !e.jp) ? s.cdata : s.vj;
        e.vk  = (s.kp && !e.kp) ? s.cdata : s.vk;
        m_q.push_back(e);
      end
    end
  endtask

  task automatic compare_model(string pfx);
    check({pfx, " mul_start"}, bus.mul_start, m_start);
    check({pfx, " mul_tag"},   bus.mul_tag,   m_tag);
    check({pfx, " mul_op_a"},  bus.mul_op_a,  m_a);
    check({pfx, " mul_op_b"},  bus.mul_op_b,  m_b);
    check({pfx, " rs_count"},  bus.rs_count,  m_q.size());
    check({pfx, " rs_full"},   bus.rs_full,   m_q.size() == ENTRIES);
  endtask

  task automatic step(stim_t s, string pfx);
    drive(s);
    @(posedge clk);
    model_edge(s);
    #1;
    compare_model(pfx);
  endtask

  task automatic check_outputs_zero(string pfx);
    check({pfx, " mul_start"}, bus.mul_start, 0);
    check({pfx, " mul_tag"},   bus.mul_tag,   0);
    check({pfx, " mul_op_a"},  bus.mul_op_a,  0);
    check({pfx, " mul_op_b"},  bus.mul_op_b,  0);
    check({pfx, " rs_count"},  bus.rs_count,  0);
    check({pfx, " rs_full"},   bus.rs_full,   0);
  endtask

  // Asserts reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(string pfx);
    drive(idle_s(0));
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero(pfx);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.iv    = ($urandom_range(0, 99) < 55);
    s.itag  = int'($urandom_range(0, 7));
    s.jp    = ($urandom_range(0, 1) == 1);
    s.qj    = int'($urandom_range(0, 7));
    s.vj    = int'($urandom_range(0, 255));
    s.kp    = ($urandom_range(0, 1) == 1);
    s.qk    = int'($urandom_range(0, 7));
    s.vk    = int'($urandom_range(0, 255));
    s.cv    = ($urandom_range(0, 99) < 45);
    s.ctag  = int'($urandom_range(0, 7));
    s.cdata = int'($urandom_range(0, 255));
    s.busy  = ($urandom_range(0, 99) < 30);
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[$];

    rst = 1'b1;
    drive(idle_s(0));
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Ready issue -> dispatch one edge later.
    vt.push_back(mk_v(mk_s(1,1, 0,0,6, 0,0,7, 0,0,0, 0), 0,0,0,0, 1,0));
    vt.push_back(mk_v(idle_s(0),                          1,1,6,7, 0,0));
    vt.push_back(mk_v(idle_s(0),                          0,1,6,7, 0,0));
    // Wakeup via CDB.
    vt.push_back(mk_v(mk_s(1,2, 1,5,0, 0,0,3, 0,0,0, 0), 0,1,6,7, 1,0));
    vt.push_back(mk_v(mk_s(0,0, 0,0,0, 0,0,0, 1,5,9, 0),
                      FWD, FWD ? 2 : 1, FWD ? 9 : 6, FWD ? 3 : 7, FWD ? 0 : 1, 0));
    vt.push_back(mk_v(idle_s(0),                          !FWD, 2,9,3, 0,0));
    vt.push_back(mk_v(idle_s(0),                          0,2,9,3, 0,0));
    // Issue-time capture.
    vt.push_back(mk_v(mk_s(1,3, 1,4,0, 0,0,5, 1,4,11, 0), 0,2,9,3, 1,0));
    vt.push_back(mk_v(idle_s(0),                          1,3,11,5, 0,0));
    vt.push_back(mk_v(idle_s(0),                          0,3,11,5, 0,0));
    // Busy multiplier, then oldest-first.
    vt.push_back(mk_v(mk_s(1,1, 0,0,2, 0,0,3, 0,0,0, 1), 0,3,11,5, 1,0));
    vt.push_back(mk_v(mk_s(1,2, 0,0,4, 0,0,5, 0,0,0, 1), 0,3,11,5, 2,1));
    vt.push_back(mk_v(idle_s(1),                          0,3,11,5, 2,1));
    vt.push_back(mk_v(idle_s(0),                          1,1,2,3, 1,0));
    vt.push_back(mk_v(idle_s(0),                          1,2,4,5, 0,0));
    vt.push_back(mk_v(idle_s(0),                          0,2,4,5, 0,0));
    // Full station drops a third issue.
    vt.push_back(mk_v(mk_s(1,5, 1,6,0, 0,0,10, 0,0,0, 0), 0,2,4,5, 1,0));
    vt.push_back(mk_v(mk_s(1,6, 1,7,0, 0,0,13, 0,0,0, 0), 0,2,4,5, 2,1));
    vt.push_back(mk_v(mk_s(1,7, 0,0,1, 0,0,1, 0,0,0, 0),  0,2,4,5, 2,1));
    vt.push_back(mk_v(mk_s(0,0, 0,0,0, 0,0,0, 1,6,8, 0),
                      FWD, FWD ? 5 : 2, FWD ? 8 : 4, FWD ? 10 : 5, FWD ? 1 : 2, !FWD));
    vt.push_back(mk_v(idle_s(0),                          !FWD, 5,8,10, 1,0));
    vt.push_back(mk_v(mk_s(0,0, 0,0,0, 0,0,0, 1,7,12, 0),
                      FWD, FWD ? 6 : 5, FWD ? 12 : 8, FWD ? 13 : 10, FWD ? 0 : 1, 0));
    vt.push_back(mk_v(idle_s(0),                          !FWD, 6,12,13, 0,0));
    vt.push_back(mk_v(idle_s(0),                          0,6,12,13, 0,0));

    for (int r = 0; r < vt.size(); r++) begin
      step(vt[r].s, $sformatf("row%0d model", r));
      check($sformatf("row%0d mul_start", r), bus.mul_start, vt[r].start);
      check($sformatf("row%0d mul_tag", r),   bus.mul_tag,   vt[r].tag);
      check($sformatf("row%0d mul_op_a", r),  bus.mul_op_a,  vt[r].a);
      check($sformatf("row%0d mul_op_b", r),  bus.mul_op_b,  vt[r].b);
      check($sformatf("row%0d rs_count", r),  bus.rs_count,  vt[r].cnt);
      check($sformatf("row%0d rs_full", r),   bus.rs_full,   vt[r].full);
    end

    // Reset while a dispatch strobe is high.
    step(mk_s(1,4, 0,0,3, 0,0,4, 0,0,0, 0), "rstA setup0");
    step(idle_s(0), "rstA setup1");
    check("rstA strobe before reset", bus.mul_start, 1);
    async_reset("rstA");
    step(idle_s(0), "rstA after0");
    step(idle_s(0), "rstA after1");

    // Reset with two busy entries; their producer broadcast afterwards must not dispatch anything.
    step(mk_s(1,2, 1,7,0, 0,0,1, 0,0,0, 0), "rstB setup0");
    step(mk_s(1,3, 0,0,2, 1,7,0, 0,0,0, 0), "rstB setup1");
    check("rstB count before reset", bus.rs_count, 2);
    async_reset("rstB");
    for (int c = 0; c < 3; c++) begin
      step(mk_s(0,0, 0,0,0, 0,0,0, 1,7,33, 0), $sformatf("rstB after%0d", c));
      check($sformatf("rstB no strobe %0d", c), bus.mul_start, 0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      step(rand_stim(), $sformatf("rand%0d", c));
    end
    for (int c = 0; c < 20; c++) begin
      step(mk_s(0,0, 0,0,0, 0,0,0, 1, c % 8, c, 0), $sformatf("drain%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
